// File: rtl/stage_database_sequencer.sv
// stage_database_sequencer: walks one stage's Haar feature database
// out of ROM and tags each word with classifier/tree position.
module stage_database_sequencer #(
  parameter int DATA_WIDTH_12   = 12,
  parameter int ADDR_WIDTH      = 12,
  parameter int CLASSIFIER_SIZE = 18,
  parameter int NUM_CLASSIFIER  = 1,
  parameter int NUM_TREE        = 9,
  parameter int BASE_ADDR       = 0
) (
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic                     start,
  input  logic                     hold,
  output logic                     rom_rd_en,
  output logic [ADDR_WIDTH-1:0]    rom_addr,
  input  logic [DATA_WIDTH_12-1:0] rom_data,
  output logic                     o_valid,
  output logic [DATA_WIDTH_12-1:0] data,
  output logic [DATA_WIDTH_12-1:0] index_database,
  output logic [DATA_WIDTH_12-1:0] index_classifier,
  output logic [DATA_WIDTH_12-1:0] index_tree,
  output logic                     end_single_classifier,
  output logic                     end_tree,
  output logic                     end_database,
  output logic                     busy,
  output logic                     o_done
);

  localparam int DW    = DATA_WIDTH_12;
  localparam int TOTAL = NUM_TREE * NUM_CLASSIFIER * CLASSIFIER_SIZE;
  localparam int CW    = (NUM_CLASSIFIER > 1) ? $clog2(NUM_CLASSIFIER) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [DW-1:0] CS_LAST = DW'(CLASSIFIER_SIZE - 1);
  localparam logic [CW-1:0] NC_LAST = CW'(NUM_CLASSIFIER - 1);
  localparam logic [DW-1:0] NT_LAST = DW'(NUM_TREE - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(TOTAL - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DW-1:0]         f_db;
  logic [DW-1:0]         f_word;
  logic [DW-1:0]         f_tree;
  logic [CW-1:0]         f_cls;
  logic [CW-1:0]         o_cls;
  logic                  issue;
  logic                  accept;
  logic                  last_fetch;

  assign issue      = (state == FETCH) && !hold;
  assign accept     = o_valid && !hold;
  assign last_fetch = (f_db == DB_LAST);

  assign rom_rd_en = issue;
  assign rom_addr  = addr;
  assign data      = rom_data;
  assign busy      = (state != IDLE);
  assign o_done    = (state == DONE);

  assign end_single_classifier = o_valid && (index_classifier == CS_LAST);
  assign end_tree     = end_single_classifier && (o_cls == NC_LAST);
  assign end_database = end_tree && (index_tree == NT_LAST);

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:  if (start) state <= FETCH;
        FETCH: if (issue && last_fetch) state <= DRAIN;
        DRAIN: if (accept) state <= DONE;
        DONE:  state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      addr   <= '0;
      f_db   <= '0;
      f_word <= '0;
      f_cls  <= '0;
      f_tree <= '0;
    end else if (state == IDLE && start) begin
      addr   <= BASE;
      f_db   <= '0;
      f_word <= '0;
      f_cls  <= '0;
      f_tree <= '0;
    end else if (issue) begin
      addr <= addr + 1'b1;
      f_db <= f_db + 1'b1;
      if (f_word == CS_LAST) begin
        f_word <= '0;
        if (f_cls == NC_LAST) begin
          f_cls  <= '0;
          f_tree <= f_tree + 1'b1;
        end else begin
          f_cls <= f_cls + 1'b1;
        end
      end else begin
        f_word <= f_word + 1'b1;
      end
    end
  end

  // metadata lags the read by one cycle so it lines up with rom_data
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      o_valid          <= 1'b0;
      index_database   <= '0;
      index_classifier <= '0;
      index_tree       <= '0;
      o_cls            <= '0;
    end else if (!hold) begin
      o_valid <= issue;
      if (issue) begin
        index_database   <= f_db;
        index_classifier <= f_word;
        index_tree       <= f_tree;
        o_cls            <= f_cls;
      end
    end
  end

endmodule

// File: tb/tb_stage_database_sequencer.sv
// tb_stage_database_sequencer: randomized scoreboard bench with a
// per-beat reference model of the stage database walk.
module tb_stage_database_sequencer;

  localparam int CS    = 3;
  localparam int NC    = 2;
  localparam int NT    = 2;
  localparam int BASE  = 16;
  localparam int TOTAL = CS * NC * NT;

  typedef struct packed {
    logic [11:0] d;
    logic [11:0] idb;
    logic [11:0] ic;
    logic [11:0] it;
    logic        esc;
    logic        et;
    logic        ed;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset_fpga, start, hold;
  logic        rom_rd_en;
  logic [11:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic        o_valid;
  logic [11:0] data, idb, ic, it;
  logic        esc, et, ed, busy, o_done;

  logic        d_start, d_hold;
  logic        d_rom_rd_en;
  logic [11:0] d_rom_addr;
  logic [11:0] d_rom_data = '0;
  logic        d_o_valid;
  logic [11:0] d_data, d_idb, d_ic, d_it;
  logic        d_esc, d_et, d_ed, d_busy, d_o_done;

  stage_database_sequencer #(
    .DATA_WIDTH_12(12), .ADDR_WIDTH(12), .CLASSIFIER_SIZE(CS),
    .NUM_CLASSIFIER(NC), .NUM_TREE(NT), .BASE_ADDR(BASE)
  ) dut (
    .clk_fpga(clk), .reset_fpga(reset_fpga), .start(start),
    .hold(hold), .rom_rd_en(rom_rd_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .o_valid(o_valid), .data(data),
    .index_database(idb), .index_classifier(ic), .index_tree(it),
    .end_single_classifier(esc), .end_tree(et), .end_database(ed),
    .busy(busy), .o_done(o_done)
  );

  stage_database_sequencer dflt (
    .clk_fpga(clk), .reset_fpga(reset_fpga), .start(d_start),
    .hold(d_hold), .rom_rd_en(d_rom_rd_en), .rom_addr(d_rom_addr),
    .rom_data(d_rom_data), .o_valid(d_o_valid), .data(d_data),
    .index_database(d_idb), .index_classifier(d_ic),
    .index_tree(d_it), .end_single_classifier(d_esc),
    .end_tree(d_et), .end_database(d_ed), .busy(d_busy),
    .o_done(d_o_done)
  );

  always @(posedge clk) if (rom_rd_en) rom_data <= rom_addr;
  always @(posedge clk) if (d_rom_rd_en) d_rom_data <= d_rom_addr;

  int    total = 0;
  int    bad = 0;
  beat_t q[$];
  bit    active = 0;
  bit    exp_done = 0;
  beat_t mb;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic beat_t model(input int k);
    beat_t b;
    int    cls;
    cls   = (k / CS) % NC;
    b.d   = 12'(BASE + k);
    b.idb = 12'(k);
    b.ic  = 12'(k % CS);
    b.it  = 12'(k / (CS * NC));
    b.esc = (k % CS) == CS - 1;
    b.et  = b.esc && (cls == NC - 1);
    b.ed  = (k == TOTAL - 1);
    return b;
  endfunction

  task automatic push_pass();
    for (int k = 0; k < TOTAL; k++) q.push_back(model(k));
    active = 1;
  endtask

  task automatic flush();
    q.delete();
    active   = 0;
    exp_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset_fpga) begin
      if (exp_done) begin
        chk("o_done", o_done, 1);
        exp_done = 0;
        active   = 0;
      end else if (o_done) begin
        chk("spurious_done", o_done, 0);
      end
      if (hold) chk("rd_en_in_hold", rom_rd_en, 0);
      if (o_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", o_valid, 0);
        end else begin
          mb = q[0];
          chk("beat", {data, idb, ic, it, esc, et, ed}, mb);
          if (!hold) begin
            void'(q.pop_front());
            if (mb.ed) exp_done = 1;
          end
        end
      end else begin
        if (q.size() > 0 && q[0].idb != 0) chk("valid_gap", o_valid, 1);
        if (esc | et | ed) chk("flags_idle", {esc, et, ed}, 0);
      end
    end
  end

  task automatic pulse_start(output int es);
    if (!active) push_pass();
    es    = cyc;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic directed_pass(input string tag, input int hk,
                               input int hn, input int sk, input int rk);
    int es, hleft, dc;
    bit hdone, sdone, got;
    hleft = 0; hdone = 0; sdone = 0; got = 0; dc = 0;
    pulse_start(es);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_rd0"}, {rom_rd_en, rom_addr}, {1'b1, 12'(BASE)});
    tick();
    chk({tag, "_beat0"}, {o_valid, data}, {1'b1, 12'(BASE)});
    for (int t = 0; t < TOTAL + 40 && !got; t++) begin
      if (o_done) begin
        got = 1;
        dc  = cyc;
      end else if (rk >= 0 && o_valid && idb == 12'(rk)) begin
        reset_fpga = 1;
        flush();
        tick();
        reset_fpga = 0;
        chk({tag, "_rst_valid"}, {o_valid, busy, o_done, rom_rd_en}, 0);
        chk({tag, "_rst_idx"}, {idb, ic, it}, 0);
        chk({tag, "_rst_flags"}, {esc, et, ed}, 0);
        return;
      end else begin
        if (!hdone && hn > 0 && o_valid && idb == 12'(hk)) begin
          hdone = 1;
          hleft = hn;
        end
        hold = (hleft > 0);
        if (hleft > 0) hleft--;
        start = !sdone && sk >= 0 && o_valid && idb == 12'(sk);
        if (start) begin
          sdone = 1;
          if (!active) push_pass();
        end
        tick();
        start = 0;
      end
    end
    hold = 0;
    chk({tag, "_done_seen"}, got, 1);
    if (got) chk({tag, "_done_cyc"}, dc, es + TOTAL + 2 + hn);
    if (!active) push_pass();
    start = 1;
    tick();
    start = 0;
    chk({tag, "_idle"}, busy, 0);
    repeat (3) tick();
  endtask

  initial begin
    int es, lc, r;
    bit got;
    reset_fpga = 1; start = 0; hold = 0;
    d_start = 0; d_hold = 0;
    repeat (3) tick();
    chk("rst_rd", {rom_rd_en, rom_addr}, 0);
    chk("rst_valid", {o_valid, busy, o_done}, 0);
    chk("rst_idx", {idb, ic, it}, 0);
    chk("rst_flags", {esc, et, ed}, 0);
    reset_fpga = 0;
    tick();

    directed_pass("basic", -1, 0, -1, -1);
    directed_pass("hold", 4, 3, -1, -1);
    directed_pass("busy_start", -1, 0, 6, -1);
    directed_pass("midrst", -1, 0, -1, 7);
    directed_pass("rerun", -1, 0, -1, -1);

    es = cyc;
    d_start = 1;
    tick();
    d_start = 0;
    got = 0;
    lc = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      if (d_o_valid && d_ed) begin
        got = 1;
        lc  = cyc;
      end else begin
        tick();
      end
    end
    chk("dflt_last_seen", got, 1);
    chk("dflt_last_cyc", lc, es + 163);
    chk("dflt_last_idx", {d_idb, d_it}, {12'd161, 12'd8});
    chk("dflt_flags", {d_esc, d_et, d_ed}, 3'b111);
    tick();
    chk("dflt_done", d_o_done, 1);
    tick();
    chk("dflt_busy", d_busy, 0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 3) begin
        reset_fpga = 1;
        start = 0;
        hold = 0;
        flush();
      end else begin
        reset_fpga = 0;
        hold  = ($urandom_range(0, 3) == 0);
        start = ($urandom_range(0, 15) == 0);
        if (start && !active) push_pass();
      end
      tick();
    end
    reset_fpga = 0; start = 0; hold = 0;
    for (int t = 0; t < 100 && (active || q.size() != 0); t++) tick();
    chk("drain_queue", q.size(), 0);
    chk("drain_active", active, 0);
    tick();
    chk("drain_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_database_sequencer.md
# stage_database_sequencer

Per-stage Haar database walker that sits directly upstream of the per-stage classifier (`fifo_stage_classifier` inside the second-phase classifier). On a start pulse it reads one stage's feature database from a synchronous ROM, word by word. It emits each word together with the `data`, `index_database`, `index_classifier` and `index_tree` values and the `end_single_classifier`, `end_tree` and `end_database` flags that the classifier consumes. One instance per stage; a hold input provides backpressure.

## Interface
- DATA_WIDTH_12, 12, width of database words and index outputs
- ADDR_WIDTH, 12, ROM address width
- CLASSIFIER_SIZE, 18, words per single classifier (feature)
- NUM_CLASSIFIER, 1, classifiers per tree
- NUM_TREE, 9, trees in this stage
- BASE_ADDR, 0, ROM address of this stage's first word
- Derived: TOTAL = NUM_TREE*NUM_CLASSIFIER*CLASSIFIER_SIZE; requires TOTAL ≤ 2^DATA_WIDTH_12 and BASE_ADDR+TOTAL ≤ 2^ADDR_WIDTH.

Ports:
- clk_fpga  in  1  single clock; all logic on its rising edge
- reset_fpga  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin a pass over the stage database
- hold  in  1  backpressure from the classifier; freezes the sequencer
- rom_rd_en  out  1  ROM read enable
- rom_addr  out  ADDR_WIDTH  ROM read address
- rom_data  in  DATA_WIDTH_12  ROM output, valid 1 cycle after rom_rd_en; ROM holds its output while rom_rd_en=0
- o_valid  out  1  current beat on the outputs is valid
- data  out  DATA_WIDTH_12  database word (combinational pass-through of rom_data)
- index_database  out  DATA_WIDTH_12  word offset within the stage, 0..TOTAL-1
- index_classifier  out  DATA_WIDTH_12  word offset within the current classifier, 0..CLASSIFIER_SIZE-1
- index_tree  out  DATA_WIDTH_12  tree number, 0..NUM_TREE-1
- end_single_classifier  out  1  beat is the last word of a classifier
- end_tree  out  1  beat is the last word of a tree
- end_database  out  1  beat is the last word of the stage
- busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States:
  - IDLE: no reads. `start`=1 → FETCH; address counter loads BASE_ADDR and fetch counters clear.
  - FETCH: `rom_rd_en` = !hold, `rom_addr` = address counter. Each non-held cycle advances the address counter and its classifier/tree sub-counters. After issuing read TOTAL-1 → DRAIN.
  - DRAIN: no reads. When the last beat is accepted → DONE.
  - DONE: `o_done`=1 for one cycle → IDLE.
- Output metadata registers (`o_valid`, indices, flags) are loaded one cycle after each issued read. This aligns them with `rom_data`.
- A beat is accepted when `o_valid` && !`hold`.
- While `hold`=1:
  - `rom_rd_en`=0.
  - All counters, the state and the output registers are frozen.
  - The current beat stays presented unchanged; `data` stays stable because the ROM holds its output.
- Counters:
  - `index_classifier` wraps CLASSIFIER_SIZE-1→0. On wrap, an internal classifier counter increments.
  - The classifier counter wraps NUM_CLASSIFIER-1→0. On wrap, `index_tree` increments.
  - `index_database` increments every beat.
  - No counter wraps past TOTAL-1 within a pass.
- Flags are combinational on the beat:
  - `end_single_classifier` = (index_classifier == CLASSIFIER_SIZE-1).
  - `end_tree` = end_single_classifier && (last classifier of tree).
  - `end_database` = end_tree && (index_tree == NUM_TREE-1).
  - All flags are qualified by `o_valid`.
- `start` while `busy`=1 is ignored. It is not queued.
- `hold` in IDLE has no effect.
- Reset mid-pass: the next cycle is IDLE with all outputs 0. ROM data in flight is discarded, and no `o_done` is produced.

## Timing
- Reset values: `rom_rd_en`, `rom_addr`, `o_valid`, all indices, all flags, `busy` and `o_done` are 0. `data` follows `rom_data` but is qualified by `o_valid`=0.
- With `start` sampled at edge E:
  - `busy`=1 and first read (`rom_addr`=BASE_ADDR) in cycle E+1.
  - Beat 0 (`o_valid`=1) in cycle E+2.
- With no hold, one beat per cycle. Beat k is in cycle E+2+k, so the last beat is in cycle E+TOTAL+1.
- `o_done` is in cycle E+TOTAL+2, and `busy` is 0 from E+TOTAL+3.
- Each hold cycle delays all later events by exactly one cycle. `o_valid` never drops between beats of a pass.
- A `start` arriving in the `o_done` cycle is ignored. A `start` one cycle later begins a new pass.

## Test plan
- Basic pass with CLASSIFIER_SIZE=3, NUM_CLASSIFIER=2, NUM_TREE=2, BASE_ADDR=16, ROM[a]=a: pulse `start` → 12 contiguous beats starting 2 cycles later, `data`=16..27.
  - `end_single_classifier` on beats 2, 5, 8, 11.
  - `end_tree` on beats 5 and 11.
  - `end_database` on beat 11 only.
  - `o_done` the next cycle.
- Index check, same configuration: `index_classifier` runs 0,1,2 repeating; `index_tree` is 0 for beats 0–5 and 1 for beats 6–11; `index_database` is 0..11.
- Hold: assert `hold` for 3 cycles while beat 4 is presented → beat 4 (`data`=20) is shown for 4 cycles, `rom_rd_en`=0 during hold, and `o_done` is 3 cycles later than in the basic pass.
- Start while busy: pulse `start` at beat 6 → sequence unchanged, exactly 12 beats, one `o_done`.
- Reset mid-pass: assert `reset_fpga` at beat 7 → next cycle `o_valid`=0, `busy`=0, indices 0, no `o_done`. A new `start` yields a full 12-beat pass from `data`=16.
- Defaults (18/1/9, TOTAL=162): last beat has `index_database`=161, `index_tree`=8, all three end flags=1, at cycle E+163.
